pe_tile_controller: RTL and testbench
=====================================

Name: pe_tile_controller

Overview:
- Initiator-side controller for the background-removal processing element (pe).
- Accepts a pixel stream and packs NUM_PIXELS pixels into the pe's packed red/green/blue input buses. Issues Start_Sum, collects the channel sums and converts them to expected (mean) RGB.
- Issues Start_BgRemoval, captures the replaced pixels, returns Ack to the pe, and streams the tile out.
- Sits between the frame pixel source/sink and one pe instance.

Parameters:
- LOG2_PIXELS, 2, log2 of pixels per tile; NUM_PIXELS = 2**LOG2_PIXELS.
- PIX_W, 8, bits per colour channel.
- THRESH_W, 18, distance-squared threshold width; 3*255^2 fits in 18 bits.

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- cfg_threshold  in  THRESH_W  background distance threshold
- cfg_desired_bg  in  PIX_W  replacement value
- pix_in_valid  in  1  input pixel valid
- pix_in_ready  out  1  input pixel accepted when valid&ready
- pix_in_rgb  in  3*PIX_W  {r,g,b} input pixel
- pix_out_valid  out  1  output pixel valid
- pix_out_ready  in  1  sink ready
- pix_out_rgb  out  3*PIX_W  {r,g,b} output pixel
- red_in/green_in/blue_in  out  PIX_W*NUM_PIXELS each  packed tile to pe; pixel k in bits [k*PIX_W +: PIX_W]
- red_exp/green_exp/blue_exp  out  PIX_W each  expected background to pe
- threshold  out  THRESH_W  to pe
- desired_bg  out  PIX_W  to pe
- Start_Sum  out  1  one-cycle pulse
- Start_BgRemoval  out  1  one-cycle pulse
- Ack  out  1  one-cycle pulse
- Qsd  in  1  pe sum done
- Qbgd  in  1  pe background removal done
- red_sum/green_sum/blue_sum  in  PIX_W+LOG2_PIXELS each  pe channel sums
- red_out/green_out/blue_out  in  PIX_W*NUM_PIXELS each  pe result tile
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE. All pulses, pix_out_valid, pix_in_ready and busy go to 0.
  - Packed buses, exp, threshold and desired_bg go to 0. Pixel counter goes to 0.
  - Reset mid-tile discards all tile data. No Ack is issued.
- IDLE:
  - pix_in_ready=1.
  - On the first handshake: latch cfg_threshold and cfg_desired_bg (held for the whole tile), store pixel 0, and go to LOAD with count=1.
- LOAD:
  - pix_in_ready=1. Each handshake stores the pixel at index count, then count+1.
  - On the handshake with count==NUM_PIXELS-1, go to SUM_START. pix_in_ready drops in the following cycle.
- SUM_START: Start_Sum=1 for exactly one cycle, then go to SUM_WAIT.
- SUM_WAIT:
  - Qsd was seen at or after the cycle following the pulse: register exp = sum >> LOG2_PIXELS per channel (truncate, no rounding), then go to BG_START.
  - Qsd high in the pulse cycle itself is ignored.
- BG_START: Start_BgRemoval=1 for one cycle; exp values are already stable. Then go to BG_WAIT.
- BG_WAIT: Qbgd seen: capture red_out/green_out/blue_out into the output buffer, then go to ACK.
- ACK: Ack=1 for one cycle, then go to DRAIN with count=0.
- DRAIN:
  - pix_out_valid=1 and pix_out_rgb = buffer pixel count.
  - Data holds stable while valid&&!ready.
  - Each handshake increments count. The handshake at count==NUM_PIXELS-1 returns to IDLE, with pix_out_valid=0 in the next cycle.
- Qsd and Qbgd are ignored outside SUM_WAIT and BG_WAIT respectively.
- Qsd and Qbgd high together in BG_WAIT: only Qbgd is acted on.
- Input is never accepted outside IDLE/LOAD, so there is no input/output overlap and at most one tile is in flight.
- Minimum latency from the last input handshake to the first pix_out_valid is 5 cycles plus pe processing time.
- Widths:
  - Sums are unsigned PIX_W+LOG2_PIXELS.
  - exp is the top PIX_W bits of the sum, so it never overflows.

Decomposition:
- Shared package holds:
  - The state encoding, one-hot 8-bit, reusing the pe state-width style: IDLE, LOAD, SUM_START, SUM_WAIT, BG_START, BG_WAIT, ACK, DRAIN.
  - PIX_W, the THRESH_W default, and a pixel-index-to-bit-offset function.
- One natural sub-module: tile_pack_unpack. It holds the indexed write into the packed input buses and the indexed read from the captured output buffer. It is shared with the future multi-pe fabric.

Test Plan:
- Four pixels all {100,150,200}, desired_bg=0, threshold=10:
  - Start_Sum pulses once and the pe model returns sums 400/600/800.
  - exp={100,150,200}.
  - Output is four {0,0,0} pixels, with one Ack pulse.
- Pixels r=10,11,12,14 with sum 47: red_exp=11 (truncated). Green and blue are checked the same way.
- pix_out_ready toggled 1,0,0,1,0,1...: every pixel appears exactly once, in order, with data stable during stalls.
- Reset asserted during SUM_WAIT and again during DRAIN:
  - Outputs are 0 asynchronously with no Ack.
  - The next tile processes correctly from index 0.
- Qsd held high throughout and Qbgd asserted two cycles after Start_BgRemoval: the bg phase completes only on Qbgd, with no extra Start pulses.
- cfg_threshold changed mid-LOAD: the threshold output keeps the value latched at the first pixel.

Source files
------------

// File: rtl/pe_tile_controller_pkg.sv
// Shared state encoding, default widths and packed-bus offset helper for the
// pe tile controller and its tile storage.
package pe_tile_controller_pkg;

   localparam int DEF_PIX_W    = 8;
   localparam int DEF_THRESH_W = 18;   // 3*255^2 fits

   typedef enum logic [7:0] {
      IDLE      = 8'b0000_0001,
      LOAD      = 8'b0000_0010,
      SUM_START = 8'b0000_0100,
      SUM_WAIT  = 8'b0000_1000,
      BG_START  = 8'b0001_0000,
      BG_WAIT   = 8'b0010_0000,
      ACK       = 8'b0100_0000,
      DRAIN     = 8'b1000_0000
   } state_t;

   // Pixel k of a packed channel bus lives at bits [k*w +: w].
   function automatic int pix_offset(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/pe_tile_controller_tile_pack_unpack.sv
// Tile storage: indexed pixel write into the packed pe input buses and
// indexed read from the captured pe result tile.
module tile_pack_unpack
   import pe_tile_controller_pkg::*;
#(
   parameter int LOG2_PIXELS = 2,
   parameter int PIX_W       = DEF_PIX_W,
   localparam int NUM_PIXELS = 2**LOG2_PIXELS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [LOG2_PIXELS-1:0]       wr_idx,
   input  logic [3*PIX_W-1:0]           wr_rgb,
   output logic [PIX_W*NUM_PIXELS-1:0]  red_in,
   output logic [PIX_W*NUM_PIXELS-1:0]  green_in,
   output logic [PIX_W*NUM_PIXELS-1:0]  blue_in,
   input  logic                         cap_en,
   input  logic [PIX_W*NUM_PIXELS-1:0]  red_out,
   input  logic [PIX_W*NUM_PIXELS-1:0]  green_out,
   input  logic [PIX_W*NUM_PIXELS-1:0]  blue_out,
   input  logic [LOG2_PIXELS-1:0]       rd_idx,
   output logic [3*PIX_W-1:0]           rd_rgb
);

   logic [NUM_PIXELS-1:0][PIX_W-1:0] r_q, g_q, b_q;
   logic [NUM_PIXELS-1:0][PIX_W-1:0] r_buf, g_buf, b_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
         r_buf <= '0;
         g_buf <= '0;
         b_buf <= '0;
      end else begin
         if (wr_en) begin
            r_q[wr_idx] <= wr_rgb[2*PIX_W +: PIX_W];
            g_q[wr_idx] <= wr_rgb[PIX_W +: PIX_W];
            b_q[wr_idx] <= wr_rgb[0 +: PIX_W];
         end
         if (cap_en) begin
            for (int k = 0; k < NUM_PIXELS; k++) begin
               r_buf[k] <= red_out[pix_offset(k, PIX_W) +: PIX_W];
               g_buf[k] <= green_out[pix_offset(k, PIX_W) +: PIX_W];
               b_buf[k] <= blue_out[pix_offset(k, PIX_W) +: PIX_W];
            end
         end
      end
   end

   assign red_in   = r_q;
   assign green_in = g_q;
   assign blue_in  = b_q;
   assign rd_rgb   = {r_buf[rd_idx], g_buf[rd_idx], b_buf[rd_idx]};

endmodule

// File: rtl/pe_tile_controller.sv
// Initiator-side controller for one background-removal pe: gathers a tile,
// runs the sum and removal phases, acknowledges, then streams the tile out.
module pe_tile_controller
   import pe_tile_controller_pkg::*;
#(
   parameter int LOG2_PIXELS = 2,
   parameter int PIX_W       = DEF_PIX_W,
   parameter int THRESH_W    = DEF_THRESH_W,
   localparam int NUM_PIXELS = 2**LOG2_PIXELS,
   localparam int SUM_W      = PIX_W + LOG2_PIXELS
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [THRESH_W-1:0]          cfg_threshold,
   input  logic [PIX_W-1:0]             cfg_desired_bg,
   input  logic                         pix_in_valid,
   output logic                         pix_in_ready,
   input  logic [3*PIX_W-1:0]           pix_in_rgb,
   output logic                         pix_out_valid,
   input  logic                         pix_out_ready,
   output logic [3*PIX_W-1:0]           pix_out_rgb,
   output logic [PIX_W*NUM_PIXELS-1:0]  red_in,
   output logic [PIX_W*NUM_PIXELS-1:0]  green_in,
   output logic [PIX_W*NUM_PIXELS-1:0]  blue_in,
   output logic [PIX_W-1:0]             red_exp,
   output logic [PIX_W-1:0]             green_exp,
   output logic [PIX_W-1:0]             blue_exp,
   output logic [THRESH_W-1:0]          threshold,
   output logic [PIX_W-1:0]             desired_bg,
   output logic                         Start_Sum,
   output logic                         Start_BgRemoval,
   output logic                         Ack,
   input  logic                         Qsd,
   input  logic                         Qbgd,
   input  logic [SUM_W-1:0]             red_sum,
   input  logic [SUM_W-1:0]             green_sum,
   input  logic [SUM_W-1:0]             blue_sum,
   input  logic [PIX_W*NUM_PIXELS-1:0]  red_out,
   input  logic [PIX_W*NUM_PIXELS-1:0]  green_out,
   input  logic [PIX_W*NUM_PIXELS-1:0]  blue_out,
   output logic                         busy
);

   localparam logic [LOG2_PIXELS-1:0] LAST_IDX = LOG2_PIXELS'(NUM_PIXELS - 1);

   state_t                 state, state_n;
   logic [LOG2_PIXELS-1:0] count;
   logic                   in_open, in_fire, out_fire, cap_en;
   logic                   sum_lsb_unused;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n         = state;
      in_open         = 1'b0;
      Start_Sum       = 1'b0;
      Start_BgRemoval = 1'b0;
      Ack             = 1'b0;
      pix_out_valid   = 1'b0;
      case (state)
         IDLE: begin
            in_open = 1'b1;
            if (pix_in_valid) state_n = LOAD;
         end
         LOAD: begin
            in_open = 1'b1;
            if (pix_in_valid && count == LAST_IDX) state_n = SUM_START;
         end
         SUM_START: begin
            Start_Sum = 1'b1;
            state_n   = SUM_WAIT;
         end
         SUM_WAIT: if (Qsd) state_n = BG_START;
         BG_START: begin
            Start_BgRemoval = 1'b1;
            state_n         = BG_WAIT;
         end
         BG_WAIT: if (Qbgd) state_n = ACK;
         ACK: begin
            Ack     = 1'b1;
            state_n = DRAIN;
         end
         DRAIN: begin
            pix_out_valid = 1'b1;
            if (pix_out_ready && count == LAST_IDX) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Ready is masked while reset is held so the source sees no acceptance.
   assign pix_in_ready = in_open && !Reset;
   assign busy         = (state != IDLE);
   assign in_fire      = pix_in_valid && in_open;
   assign out_fire     = pix_out_valid && pix_out_ready;
   assign cap_en       = (state == BG_WAIT) && Qbgd;

   // The mean is the top PIX_W bits of each sum; the low bits are dropped.
   assign sum_lsb_unused = ^{red_sum[LOG2_PIXELS-1:0], green_sum[LOG2_PIXELS-1:0],
                             blue_sum[LOG2_PIXELS-1:0]};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count      <= '0;
         threshold  <= '0;
         desired_bg <= '0;
         red_exp    <= '0;
         green_exp  <= '0;
         blue_exp   <= '0;
      end else begin
         if (state == IDLE && in_fire) begin
            threshold  <= cfg_threshold;
            desired_bg <= cfg_desired_bg;
         end
         if (state == SUM_WAIT && Qsd) begin
            red_exp   <= red_sum[SUM_W-1 -: PIX_W];
            green_exp <= green_sum[SUM_W-1 -: PIX_W];
            blue_exp  <= blue_sum[SUM_W-1 -: PIX_W];
         end
         if (state == ACK)              count <= '0;
         else if (in_fire || out_fire)  count <= count + 1'b1;
      end
   end

   tile_pack_unpack #(
      .LOG2_PIXELS (LOG2_PIXELS),
      .PIX_W       (PIX_W)
   ) u_tile (
      .clk       (Clk),
      .rst       (Reset),
      .wr_en     (in_fire),
      .wr_idx    (count),
      .wr_rgb    (pix_in_rgb),
      .red_in    (red_in),
      .green_in  (green_in),
      .blue_in   (blue_in),
      .cap_en    (cap_en),
      .red_out   (red_out),
      .green_out (green_out),
      .blue_out  (blue_out),
      .rd_idx    (count),
      .rd_rgb    (pix_out_rgb)
   );

endmodule

// File: tb/tb_pe_tile_controller.sv
// Directed + randomized bench for pe_tile_controller with a behavioural pe
// model and a tile-level reference computed from plain arithmetic.
module tb_pe_tile_controller;
   localparam int L2 = 2;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TW = 18;
   localparam int SW = W + L2;

   logic            Clk = 1'b0;
   logic            Reset = 1'b0;
   logic [TW-1:0]   cfg_threshold = '0;
   logic [W-1:0]    cfg_desired_bg = '0;
   logic            pix_in_valid = 1'b0;
   logic            pix_in_ready;
   logic [3*W-1:0]  pix_in_rgb = '0;
   logic            pix_out_valid;
   logic            pix_out_ready = 1'b0;
   logic [3*W-1:0]  pix_out_rgb;
   logic [W*N-1:0]  red_in, green_in, blue_in;
   logic [W-1:0]    red_exp, green_exp, blue_exp;
   logic [TW-1:0]   threshold;
   logic [W-1:0]    desired_bg;
   logic            Start_Sum, Start_BgRemoval, Ack;
   logic            Qsd = 1'b0, Qbgd = 1'b0;
   logic [SW-1:0]   red_sum = '0, green_sum = '0, blue_sum = '0;
   logic [W*N-1:0]  red_out = '0, green_out = '0, blue_out = '0;
   logic            busy;

   pe_tile_controller #(.LOG2_PIXELS(L2), .PIX_W(W), .THRESH_W(TW)) dut (
      .Clk(Clk), .Reset(Reset), .cfg_threshold(cfg_threshold), .cfg_desired_bg(cfg_desired_bg),
      .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_rgb(pix_in_rgb),
      .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready), .pix_out_rgb(pix_out_rgb),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
      .threshold(threshold), .desired_bg(desired_bg),
      .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
      .Qsd(Qsd), .Qbgd(Qbgd), .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .busy(busy)
   );

   always #5 Clk = ~Clk;

   int errors = 0, checks = 0;
   int n_ss = 0, n_sb = 0, n_ak = 0;
   logic [W-1:0] pr[N], pg[N], pb[N];

   always @(posedge Clk) begin
      if (!Reset) begin
         n_ss += int'(Start_Sum);
         n_sb += int'(Start_BgRemoval);
         n_ak += int'(Ack);
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk); #1;
   endtask

   task automatic rand_pixels();
      for (int i = 0; i < N; i++) begin
         pr[i] = W'($urandom_range(0, 255));
         pg[i] = W'($urandom_range(0, 255));
         pb[i] = W'($urandom_range(0, 255));
      end
   endtask

   task automatic do_reset();
      int ak;
      ak = n_ak;
      Reset = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", pix_in_ready, 0);
      chk("rst_out_valid", pix_out_valid, 0);
      chk("rst_pulses", {Start_Sum, Start_BgRemoval, Ack}, 0);
      chk("rst_tile_bus", {red_in, green_in, blue_in}, 0);
      chk("rst_exp_cfg", {red_exp, green_exp, blue_exp, threshold, desired_bg}, 0);
      pix_in_valid = 1'b0; Qsd = 1'b0; Qbgd = 1'b0; pix_out_ready = 1'b0;
      step();
      Reset = 1'b0;
      step();
      chk("rst_no_ack", n_ak - ak, 0);
   endtask

   // reset_at: 0 none, 1 during SUM_WAIT, 2 during DRAIN after one pixel.
   // ready_mode: 0 always ready, 1 pattern 1,0,0,1,0,1..., 2 random.
   task automatic run_tile(input int thr, input int dbg, input bit thr_change, input bit qsd_early,
                           input bit qsd_hold, input int ready_mode, input int reset_at);
      int sr, sg, sbl, mr, mg, mb, dr, dg, db, d, ss0, sb0, ak0, idx, cyc, g, rdy;
      int pat[6] = '{1, 0, 0, 1, 0, 1};
      logic [3*W-1:0] exp_out[N];
      logic [W*N-1:0] pk_r, pk_g, pk_b, res_r, res_g, res_b;
      sr = 0; sg = 0; sbl = 0;
      for (int i = 0; i < N; i++) begin
         sr += int'(pr[i]); sg += int'(pg[i]); sbl += int'(pb[i]);
      end
      mr = sr / N; mg = sg / N; mb = sbl / N;
      for (int i = 0; i < N; i++) begin
         dr = int'(pr[i]) - mr; dg = int'(pg[i]) - mg; db = int'(pb[i]) - mb;
         d = dr*dr + dg*dg + db*db;
         pk_r[i*W +: W] = pr[i]; pk_g[i*W +: W] = pg[i]; pk_b[i*W +: W] = pb[i];
         if (d < thr) begin
            res_r[i*W +: W] = W'(dbg); res_g[i*W +: W] = W'(dbg); res_b[i*W +: W] = W'(dbg);
         end else begin
            res_r[i*W +: W] = pr[i]; res_g[i*W +: W] = pg[i]; res_b[i*W +: W] = pb[i];
         end
         exp_out[i] = {res_r[i*W +: W], res_g[i*W +: W], res_b[i*W +: W]};
      end
      ss0 = n_ss; sb0 = n_sb; ak0 = n_ak;
      cfg_threshold = TW'(thr); cfg_desired_bg = W'(dbg);

      for (int i = 0; i < N; i++) begin
         pix_in_valid = 1'b1;
         pix_in_rgb   = {pr[i], pg[i], pb[i]};
         g = 0;
         while (!pix_in_ready && g < 20) begin step(); g++; end
         chk("in_ready", pix_in_ready, 1);
         step();
         pix_in_valid = 1'b0;
         if (i == 0 && thr_change) begin
            cfg_threshold  = ~cfg_threshold;
            cfg_desired_bg = ~cfg_desired_bg;
         end
         if (i < N-1 && $urandom_range(0, 1) == 1) step();
      end

      chk("start_sum", Start_Sum, 1);
      chk("in_ready_drop", pix_in_ready, 0);
      chk("tile_bus", {red_in, green_in, blue_in}, {pk_r, pk_g, pk_b});
      chk("cfg_latched", {threshold, desired_bg}, {TW'(thr), W'(dbg)});
      red_sum = SW'(sr); green_sum = SW'(sg); blue_sum = SW'(sbl);
      Qsd = qsd_early | qsd_hold;
      step();
      chk("no_early_bg", Start_BgRemoval, 0);
      if (reset_at == 1) begin do_reset(); return; end
      if (!qsd_hold) begin
         Qsd = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            step();
            chk("sum_wait_hold", Start_BgRemoval, 0);
         end
         Qsd = 1'b1;
      end
      step();
      chk("start_bg", Start_BgRemoval, 1);
      chk("exp_mean", {red_exp, green_exp, blue_exp}, {W'(mr), W'(mg), W'(mb)});
      if (!qsd_hold) Qsd = 1'b0;
      red_out = res_r; green_out = res_g; blue_out = res_b;
      step();
      repeat (qsd_hold ? 1 : $urandom_range(0, 3)) begin
         chk("bg_wait_hold", {Ack, busy, Start_Sum, Start_BgRemoval}, 4'b0100);
         step();
      end
      Qbgd = 1'b1;
      step();
      chk("ack", Ack, 1);
      Qbgd = 1'b0; Qsd = 1'b0;
      step();
      chk("pulse_counts", {8'(n_ss - ss0), 8'(n_sb - sb0), 8'(n_ak - ak0)}, 24'h010101);

      idx = 0; cyc = 0;
      while (idx < N && cyc < 100) begin
         case (ready_mode)
            0:       rdy = 1;
            1:       rdy = pat[cyc % 6];
            default: rdy = int'($urandom_range(0, 1));
         endcase
         pix_out_ready = (rdy != 0);
         chk("out_valid", pix_out_valid, 1);
         chk("out_rgb", pix_out_rgb, exp_out[idx]);
         if (rdy != 0) idx++;
         step();
         cyc++;
         if (reset_at == 2 && idx == 1) begin do_reset(); return; end
      end
      pix_out_ready = 1'b0;
      chk("drain_done", idx, N);
      chk("out_valid_low", {pix_out_valid, busy}, 0);
      chk("no_extra_ack", n_ak - ak0, 1);
   endtask

   initial begin
      #2;
      do_reset();

      for (int i = 0; i < N; i++) begin pr[i] = 100; pg[i] = 150; pb[i] = 200; end
      run_tile(10, 0, 0, 0, 0, 0, 0);

      pr = '{8'd10, 8'd11, 8'd12, 8'd14};
      pg = '{8'd20, 8'd21, 8'd22, 8'd24};
      pb = '{8'd250, 8'd251, 8'd252, 8'd255};
      run_tile(0, 0, 0, 0, 0, 0, 0);

      rand_pixels(); run_tile(5000, 7, 0, 0, 0, 1, 0);
      rand_pixels(); run_tile(100, 3, 0, 1, 0, 0, 0);
      rand_pixels(); run_tile(9000, 9, 0, 0, 0, 0, 1);
      rand_pixels(); run_tile(9000, 9, 0, 0, 0, 2, 0);
      rand_pixels(); run_tile(12000, 1, 0, 0, 0, 0, 2);
      rand_pixels(); run_tile(12000, 2, 0, 0, 0, 1, 0);
      rand_pixels(); run_tile(20000, 5, 0, 0, 1, 0, 0);
      rand_pixels(); run_tile(15000, 4, 1, 0, 0, 0, 0);

      repeat (8) begin
         rand_pixels();
         run_tile(int'($urandom_range(0, 30000)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  int'($urandom_range(0, 2)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
